// File: rtl/ss_ptr_bank_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : ss_ptr_bank_unit_pkg
// Brief  : Shared types for the shadow-stack pointer unit. Defines the
//          shadow-stack op encoding and the pending-op record kept in the
//          pending FIFO.
// Rev    : 1.0 - initial release
// ============================================================================
package ss_ptr_bank_unit_pkg;

  // Address / SSP width of the core this unit is built for.
  localparam int unsigned XLEN = 64;

  typedef logic [XLEN-1:0] xlen_t;

  typedef enum logic [2:0] {
    SS_PUSH    = 3'd0,
    SS_POP     = 3'd1,
    SS_POPCHK  = 3'd2,
    SS_RR      = 3'd3,
    SS_AMOSWAP = 3'd4
  } ss_op_e;

  // One issued-but-not-completed op: the bank it belongs to and the SSP
  // value that becomes architectural when it completes.
  typedef struct packed {
    logic [1:0] mode;
    xlen_t      ssp;
  } ss_pend_t;

endpackage
`default_nettype wire

// File: rtl/ss_ptr_bank_unit_pend_fifo.sv
`default_nettype none
// ============================================================================
// Module : ss_ptr_pend_fifo
// Brief  : Circular FIFO of pending shadow-stack ops.
// Ports  : clk_i, rst_ni      clock, async active-low reset
//          push_i, data_i     enqueue one entry
//          pop_i              dequeue the oldest entry (ignored when empty)
//          clear_i            discard every entry (after this cycle's pop)
//          data_o             oldest entry
//          full_o, empty_o    occupancy flags from registered count
// Rev    : 1.0 - initial release
// ============================================================================
module ss_ptr_pend_fifo
  import ss_ptr_bank_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  ss_pend_t data_i,
  input  logic     pop_i,
  input  logic     clear_i,
  output ss_pend_t data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  ss_pend_t      mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count == '0);
  assign full_o  = (count == DEPTH_CNT);
  assign data_o  = mem[rd_ptr];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear_i) begin
      // A clear discards everything, including anything pushed this cycle.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem[wr_ptr] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/ss_ptr_bank_unit.sv
`default_nettype none
// ============================================================================
// Module : ss_ptr_bank_unit
// Brief  : Shadow-stack pointer unit, one SSP bank per privilege mode.
//          Keeps speculative and architectural SSPs, generates the access
//          address of each op, bound-checks it and rolls back on flush.
// Ports  : clk_i/rst_ni            clock, async active-low reset
//          flush_i                 squash all uncompleted ops
//          mode_i                  current bank
//          op_valid_i/op_ready_o/op_i  op issue handshake
//          op_addr_o               access address of the issuing op
//          done_i                  oldest pending op completed
//          base_i/limit_i          bounds of current bank
//          csr_we_i/csr_mode_i/csr_wdata_i/csr_ready_o  CSR SSP write
//          ssp_o/spec_ssp_o        arch / spec SSP of mode_i
//          fault_o/fault_ovf_o     registered bound-violation pulse
// Rev    : 1.0 - initial release
// ============================================================================
module ss_ptr_bank_unit
  import ss_ptr_bank_unit_pkg::*;
#(
  parameter int unsigned NR_MODES   = 3,
  parameter int unsigned PEND_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic [1:0] mode_i,
  input  logic       op_valid_i,
  output logic       op_ready_o,
  input  ss_op_e     op_i,
  output xlen_t      op_addr_o,
  input  logic       done_i,
  input  xlen_t      base_i,
  input  xlen_t      limit_i,
  input  logic       csr_we_i,
  input  logic [1:0] csr_mode_i,
  input  xlen_t      csr_wdata_i,
  output logic       csr_ready_o,
  output xlen_t      ssp_o,
  output xlen_t      spec_ssp_o,
  output logic       fault_o,
  output logic       fault_ovf_o
);

  localparam xlen_t ENTRY_BYTES = xlen_t'(XLEN / 8);

  function automatic logic mode_ok(input logic [1:0] m);
    return 32'(m) < NR_MODES;
  endfunction

  xlen_t         arch_q [NR_MODES];
  xlen_t         spec_q [NR_MODES];
  xlen_t         arch_d [NR_MODES];
  xlen_t         spec_d [NR_MODES];

  xlen_t         cur_spec;
  xlen_t         new_ssp;
  logic [XLEN:0] wide;
  logic          violation;
  logic          is_push;
  logic          issue_ok;
  logic          accept;
  logic          fault_d;

  ss_pend_t      head;
  ss_pend_t      pend_in;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          csr_ok;

  // --------------------------------------------------------------------------
  // Current bank readout
  // --------------------------------------------------------------------------
  always_comb begin
    cur_spec   = '0;
    ssp_o      = '0;
    spec_ssp_o = '0;
    if (mode_ok(mode_i)) begin
      cur_spec   = spec_q[mode_i];
      ssp_o      = arch_q[mode_i];
      spec_ssp_o = spec_q[mode_i];
    end
  end

  // --------------------------------------------------------------------------
  // Address, next SSP and bound check. The extra top bit of 'wide' carries
  // the borrow/carry so a modulo wrap is always reported as a violation.
  // --------------------------------------------------------------------------
  always_comb begin
    wide      = {1'b0, cur_spec};
    new_ssp   = cur_spec;
    op_addr_o = cur_spec;
    violation = 1'b0;
    is_push   = 1'b0;
    case (op_i)
      SS_PUSH: begin
        is_push   = 1'b1;
        wide      = {1'b0, cur_spec} - {1'b0, ENTRY_BYTES};
        new_ssp   = wide[XLEN-1:0];
        op_addr_o = wide[XLEN-1:0];
        violation = wide[XLEN] | (wide[XLEN-1:0] < limit_i);
      end
      SS_POP, SS_POPCHK: begin
        wide      = {1'b0, cur_spec} + {1'b0, ENTRY_BYTES};
        new_ssp   = wide[XLEN-1:0];
        violation = wide[XLEN] | (wide[XLEN-1:0] > base_i);
      end
      default: ;
    endcase
  end

  assign op_ready_o  = ~fifo_full & ~flush_i & ~csr_we_i;
  assign csr_ready_o = fifo_empty;
  assign csr_ok      = csr_we_i & fifo_empty & mode_ok(csr_mode_i);
  assign issue_ok    = op_valid_i & op_ready_o & mode_ok(mode_i);
  assign accept      = issue_ok & ~violation;
  assign fault_d     = issue_ok & violation;
  assign fifo_pop    = done_i & ~fifo_empty;
  assign pend_in     = '{mode: mode_i, ssp: new_ssp};

  ss_ptr_pend_fifo #(
    .DEPTH (PEND_DEPTH)
  ) u_pend_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (accept),
    .data_i  (pend_in),
    .pop_i   (fifo_pop),
    .clear_i (flush_i),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // --------------------------------------------------------------------------
  // Bank next-state. Order matters: completion first, so a same-cycle flush
  // restores speculative banks from the freshly committed values; the CSR
  // write is last because it can only coincide with an empty FIFO.
  // --------------------------------------------------------------------------
  always_comb begin
    arch_d = arch_q;
    spec_d = spec_q;
    if (fifo_pop && mode_ok(head.mode)) begin
      arch_d[head.mode] = head.ssp;
    end
    if (accept) begin
      spec_d[mode_i] = new_ssp;
    end
    if (flush_i) begin
      for (int m = 0; m < int'(NR_MODES); m++) begin
        spec_d[m] = arch_d[m];
      end
    end
    if (csr_ok) begin
      arch_d[csr_mode_i] = csr_wdata_i;
      spec_d[csr_mode_i] = csr_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int m = 0; m < int'(NR_MODES); m++) begin
        arch_q[m] <= '0;
        spec_q[m] <= '0;
      end
      fault_o     <= 1'b0;
      fault_ovf_o <= 1'b0;
    end else begin
      arch_q      <= arch_d;
      spec_q      <= spec_d;
      fault_o     <= fault_d;
      fault_ovf_o <= fault_d & is_push;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ss_ptr_bank_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_ss_ptr_bank_unit
// Brief  : Self-checking bench for ss_ptr_bank_unit: directed scenarios plus
//          randomized traffic against a queue-based reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ss_ptr_bank_unit;
  import ss_ptr_bank_unit_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       flush_i;
  logic [1:0] mode_i;
  logic       op_valid_i;
  logic       op_ready_o;
  ss_op_e     op_i;
  xlen_t      op_addr_o;
  logic       done_i;
  xlen_t      base_i;
  xlen_t      limit_i;
  logic       csr_we_i;
  logic [1:0] csr_mode_i;
  xlen_t      csr_wdata_i;
  logic       csr_ready_o;
  xlen_t      ssp_o;
  xlen_t      spec_ssp_o;
  logic       fault_o;
  logic       fault_ovf_o;

  always #5 clk = ~clk;

  ss_ptr_bank_unit #(.NR_MODES(3), .PEND_DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .mode_i      (mode_i),
    .op_valid_i  (op_valid_i),
    .op_ready_o  (op_ready_o),
    .op_i        (op_i),
    .op_addr_o   (op_addr_o),
    .done_i      (done_i),
    .base_i      (base_i),
    .limit_i     (limit_i),
    .csr_we_i    (csr_we_i),
    .csr_mode_i  (csr_mode_i),
    .csr_wdata_i (csr_wdata_i),
    .csr_ready_o (csr_ready_o),
    .ssp_o       (ssp_o),
    .spec_ssp_o  (spec_ssp_o),
    .fault_o     (fault_o),
    .fault_ovf_o (fault_ovf_o)
  );

  // Reference model: per-bank SSP values and an ordered list of pending ops.
  typedef struct {
    logic [1:0]  m;
    logic [63:0] v;
  } pe_t;

  logic [63:0] m_arch [4];
  logic [63:0] m_spec [4];
  logic [63:0] bases  [4];
  logic [63:0] limits [4];
  pe_t         q [$];
  logic        exp_fault;
  logic        exp_ovf;
  logic [63:0] seen_addr;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 4; m++) begin
      m_arch[m] = '0;
      m_spec[m] = '0;
    end
    q.delete();
    exp_fault = 1'b0;
    exp_ovf   = 1'b0;
  endtask

  // One clock cycle: drive, check combinational outputs, advance the model,
  // clock, then check registered outputs.
  task automatic cyc(input logic v, input ss_op_e op, input logic [1:0] md,
                     input logic dn, input logic fl, input logic we,
                     input logic [1:0] cm, input logic [63:0] wd);
    logic        rdy, cok, viol, acc;
    logic [64:0] nxt;
    logic [63:0] sp, addr;
    pe_t         e;
    op_valid_i  = v;
    op_i        = op;
    mode_i      = md;
    done_i      = dn;
    flush_i     = fl;
    csr_we_i    = we;
    csr_mode_i  = cm;
    csr_wdata_i = wd;
    base_i      = bases[md];
    limit_i     = limits[md];
    #1;
    sp   = m_spec[md];
    rdy  = (q.size() < DEPTH) && !fl && !we;
    cok  = (q.size() == 0);
    viol = 1'b0;
    nxt  = {1'b0, sp};
    addr = sp;
    if (op == SS_PUSH) begin
      addr = sp - 64'd8;
      nxt  = {1'b0, addr};
      viol = (sp < 64'd8) || (addr < limits[md]);
    end else if (op == SS_POP || op == SS_POPCHK) begin
      nxt  = {1'b0, sp} + 65'd8;
      viol = nxt > {1'b0, bases[md]};
    end
    chk("op_ready", {63'd0, op_ready_o}, {63'd0, rdy});
    chk("csr_ready", {63'd0, csr_ready_o}, {63'd0, cok});
    if (v) chk("op_addr", op_addr_o, addr);
    seen_addr = op_addr_o;
    acc       = v && rdy && !viol;
    exp_fault = v && rdy && viol;
    exp_ovf   = exp_fault && (op == SS_PUSH);
    if (dn && q.size() > 0) begin
      e = q.pop_front();
      m_arch[e.m] = e.v;
    end
    if (acc) begin
      q.push_back('{md, nxt[63:0]});
      m_spec[md] = nxt[63:0];
    end
    if (fl) begin
      q.delete();
      for (int m = 0; m < 4; m++) m_spec[m] = m_arch[m];
    end
    if (we && cok) begin
      m_arch[cm] = wd;
      m_spec[cm] = wd;
    end
    @(posedge clk);
    #1;
    chk("ssp", ssp_o, m_arch[md]);
    chk("spec_ssp", spec_ssp_o, m_spec[md]);
    chk("fault", {63'd0, fault_o}, {63'd0, exp_fault});
    chk("fault_ovf", {63'd0, fault_ovf_o}, {63'd0, exp_ovf});
    op_valid_i = 1'b0;
    done_i     = 1'b0;
    flush_i    = 1'b0;
    csr_we_i   = 1'b0;
  endtask

  task automatic issue(input ss_op_e op, input logic [1:0] md);
    cyc(1'b1, op, md, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0);
  endtask

  task automatic idle(input logic [1:0] md, input logic dn, input logic fl);
    cyc(1'b0, SS_RR, md, dn, fl, 1'b0, 2'd0, 64'd0);
  endtask

  task automatic csr_wr(input logic [1:0] cm, input logic [63:0] wd);
    cyc(1'b0, SS_RR, cm, 1'b0, 1'b0, 1'b1, cm, wd);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      logic [1:0]  md, cm;
      logic [63:0] wd;
      md = 2'($urandom_range(0, 2));
      cm = 2'($urandom_range(0, 2));
      wd = bases[cm] - 64'(8 * $urandom_range(0, 9));
      cyc(($urandom_range(0, 1) == 1), ss_op_e'($urandom_range(0, 4)), md,
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 15) == 0), cm, wd);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    bases[0] = 64'h1000; limits[0] = 64'h0F00;
    bases[1] = 64'h2000; limits[1] = 64'h1F00;
    bases[2] = 64'h3000; limits[2] = 64'h2F00;
    bases[3] = 64'h0;    limits[3] = 64'h0;
    rst_ni = 1'b0; flush_i = 1'b0; mode_i = 2'd0; op_valid_i = 1'b0;
    op_i = SS_RR; done_i = 1'b0; base_i = '0; limit_i = '0;
    csr_we_i = 1'b0; csr_mode_i = 2'd0; csr_wdata_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    chk("rst_ssp", ssp_o, 64'd0);
    chk("rst_spec", spec_ssp_o, 64'd0);
    chk("rst_fault", {63'd0, fault_o}, 64'd0);
    chk("rst_csr_ready", {63'd0, csr_ready_o}, 64'd1);

    // Basic push and commit.
    csr_wr(2'd0, 64'h1000);
    issue(SS_PUSH, 2'd0);
    chk("s1_addr", seen_addr, 64'h0FF8);
    chk("s1_spec", spec_ssp_o, 64'h0FF8);
    chk("s1_arch", ssp_o, 64'h1000);
    idle(2'd0, 1'b1, 1'b0);
    chk("s1_commit", ssp_o, 64'h0FF8);

    // Three pushes, a pop, then flush.
    csr_wr(2'd0, 64'h1000);
    issue(SS_PUSH, 2'd0);
    issue(SS_PUSH, 2'd0);
    issue(SS_PUSH, 2'd0);
    chk("s2_spec3", spec_ssp_o, 64'h0FE8);
    issue(SS_POP, 2'd0);
    chk("s2_pop_addr", seen_addr, 64'h0FE8);
    chk("s2_spec_pop", spec_ssp_o, 64'h0FF0);
    idle(2'd0, 1'b0, 1'b1);
    chk("s2_flush_spec", spec_ssp_o, 64'h1000);
    chk("s2_flush_empty", {63'd0, csr_ready_o}, 64'd1);

    // Overflow and underflow at the bounds.
    csr_wr(2'd0, 64'h0F00);
    issue(SS_PUSH, 2'd0);
    chk("s3_fault", {63'd0, fault_o}, 64'd1);
    chk("s3_ovf", {63'd0, fault_ovf_o}, 64'd1);
    chk("s3_spec", spec_ssp_o, 64'h0F00);
    chk("s3_noq", {63'd0, csr_ready_o}, 64'd1);
    csr_wr(2'd0, 64'h1000);
    issue(SS_POP, 2'd0);
    chk("s4_fault", {63'd0, fault_o}, 64'd1);
    chk("s4_ovf", {63'd0, fault_ovf_o}, 64'd0);

    // Fill the FIFO across banks, then done+flush together.
    csr_wr(2'd1, 64'h2000);
    csr_wr(2'd2, 64'h3000);
    issue(SS_PUSH, 2'd0);
    issue(SS_PUSH, 2'd0);
    issue(SS_PUSH, 2'd1);
    issue(SS_PUSH, 2'd2);
    chk("s5_full_rdy", {63'd0, op_ready_o}, 64'd0);
    chk("s5_full_csr", {63'd0, csr_ready_o}, 64'd0);
    cyc(1'b1, SS_PUSH, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 64'd0);
    cyc(1'b0, SS_RR, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 64'd0);
    chk("s5_arch0", ssp_o, 64'h0FF0);
    idle(2'd1, 1'b0, 1'b0);
    chk("s5_spec1", spec_ssp_o, 64'h2000);
    idle(2'd2, 1'b0, 1'b0);
    chk("s5_spec2", spec_ssp_o, 64'h3000);

    // Interleaved modes.
    issue(SS_PUSH, 2'd0);
    issue(SS_PUSH, 2'd1);
    idle(2'd1, 1'b1, 1'b0);
    idle(2'd1, 1'b1, 1'b0);
    chk("s6_arch1", ssp_o, 64'h1FF8);
    idle(2'd0, 1'b0, 1'b0);
    chk("s6_arch0", ssp_o, 64'h0FE8);

    // Modulo wrap cases.
    limits[2] = 64'h0;
    csr_wr(2'd2, 64'h0);
    issue(SS_PUSH, 2'd2);
    chk("s7_wrap_push", {63'd0, fault_o}, 64'd1);
    bases[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    csr_wr(2'd2, 64'hFFFF_FFFF_FFFF_FFF8);
    issue(SS_POP, 2'd2);
    chk("s7_wrap_pop", {63'd0, fault_o}, 64'd1);
    chk("s7_wrap_spec", spec_ssp_o, 64'hFFFF_FFFF_FFFF_FFF8);
    bases[2] = 64'h3000; limits[2] = 64'h2F00;
    csr_wr(2'd2, 64'h3000);

    rand_cycles(300);

    // Asynchronous reset in the middle of traffic.
    issue(SS_PUSH, 2'd0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("areset_ssp", ssp_o, 64'd0);
    chk("areset_spec", spec_ssp_o, 64'd0);
    chk("areset_fault", {63'd0, fault_o}, 64'd0);
    chk("areset_ovf", {63'd0, fault_ovf_o}, 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    for (int m = 0; m < 3; m++) csr_wr(2'(m), bases[m]);
    rand_cycles(300);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
